// File: rtl/inst_decode_stage.sv
// RV32I/RV64I decode stage: decodes {pc, ir} into fields, immediate and control flags,
// and buffers results in an in-order DEPTH-entry queue with valid/ready on both sides.
module inst_decode_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       flush_i,
   input  logic                       v_i,
   output logic                       ready_o,
   input  logic [XLEN-1:0]            pc_i,
   input  logic [31:0]                ir_i,
   output logic                       v_o,
   input  logic                       ready_i,
   output logic [XLEN-1:0]            pc_o,
   output logic [6:0]                 opcode_o,
   output logic [4:0]                 rd_o,
   output logic [4:0]                 rs1_o,
   output logic [4:0]                 rs2_o,
   output logic [2:0]                 funct3_o,
   output logic [6:0]                 funct7_o,
   output logic [XLEN-1:0]            imm_o,
   output logic [7:0]                 ctrl_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam int C_IMM     = 0;
   localparam int C_BR      = 1;
   localparam int C_JMP     = 2;
   localparam int C_RDW     = 3;
   localparam int C_DMEM_R  = 4;
   localparam int C_DMEM_W  = 5;
   localparam int C_ADDPC   = 6;
   localparam int C_ILLEGAL = 7;

   // Sign-extend a 32-bit immediate to the datapath width.
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   logic [6:0]      dec_opcode_s;
   logic [4:0]      dec_rd_s;
   logic [4:0]      dec_rs1_s;
   logic [4:0]      dec_rs2_s;
   logic [2:0]      dec_funct3_s;
   logic [6:0]      dec_funct7_s;
   logic [XLEN-1:0] dec_imm_s;
   logic [7:0]      dec_ctrl_s;
   logic [31:0]     imm_i_s;
   logic [31:0]     imm_s_s;
   logic [31:0]     imm_b_s;
   logic [31:0]     imm_u_s;
   logic [31:0]     imm_j_s;
   logic [XLEN-1:0] shamt_s;

   // Raw immediate formats, all sign-extended from ir[31] within 32 bits.
   always_comb begin
      imm_i_s = {{20{ir_i[31]}}, ir_i[31:20]};
      imm_s_s = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
      imm_b_s = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
      imm_u_s = {ir_i[31:12], 12'h000};
      imm_j_s = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
      shamt_s = '0;
      if (XLEN == 64) begin
         shamt_s[5:0] = ir_i[25:20];
      end else begin
         shamt_s[4:0] = ir_i[24:20];
      end
   end

   // Per-opcode field shaping, immediate select and control flags.
   always_comb begin
      dec_opcode_s = ir_i[6:0];
      dec_rd_s     = ir_i[11:7];
      dec_rs1_s    = ir_i[19:15];
      dec_rs2_s    = ir_i[24:20];
      dec_funct3_s = ir_i[14:12];
      dec_funct7_s = ir_i[31:25];
      dec_imm_s    = '0;
      dec_ctrl_s   = 8'h00;
      case (ir_i[6:0])
         OPC_LUI: begin
            dec_imm_s          = sext32(imm_u_s);
            dec_rs1_s          = 5'd0;
            dec_funct3_s       = 3'b000;
            dec_funct7_s       = 7'd0;
            dec_ctrl_s[C_IMM]  = 1'b1;
            dec_ctrl_s[C_RDW]  = 1'b1;
         end
         OPC_AUIPC: begin
            dec_imm_s           = sext32(imm_u_s);
            dec_ctrl_s[C_IMM]   = 1'b1;
            dec_ctrl_s[C_ADDPC] = 1'b1;
            dec_ctrl_s[C_RDW]   = 1'b1;
         end
         OPC_JAL: begin
            dec_imm_s           = sext32(imm_j_s);
            dec_ctrl_s[C_IMM]   = 1'b1;
            dec_ctrl_s[C_ADDPC] = 1'b1;
            dec_ctrl_s[C_JMP]   = 1'b1;
            dec_ctrl_s[C_RDW]   = 1'b1;
         end
         OPC_JALR: begin
            dec_imm_s         = sext32(imm_i_s);
            dec_funct3_s      = 3'b000;
            dec_funct7_s      = 7'd0;
            dec_ctrl_s[C_IMM] = 1'b1;
            dec_ctrl_s[C_JMP] = 1'b1;
            dec_ctrl_s[C_RDW] = 1'b1;
         end
         OPC_BRANCH: begin
            dec_imm_s         = sext32(imm_b_s);
            dec_ctrl_s[C_IMM] = 1'b1;
            dec_ctrl_s[C_BR]  = 1'b1;
         end
         OPC_LOAD: begin
            dec_imm_s            = sext32(imm_i_s);
            dec_ctrl_s[C_IMM]    = 1'b1;
            dec_ctrl_s[C_DMEM_R] = 1'b1;
            dec_ctrl_s[C_RDW]    = 1'b1;
         end
         OPC_STORE: begin
            dec_imm_s            = sext32(imm_s_s);
            dec_ctrl_s[C_IMM]    = 1'b1;
            dec_ctrl_s[C_DMEM_W] = 1'b1;
         end
         OPC_OPIMM: begin
            // Shifts carry shamt as the immediate; funct7 keeps bit 5 so SRAI stays distinct.
            if ((ir_i[14:12] == 3'b001) || (ir_i[14:12] == 3'b101)) begin
               dec_imm_s    = shamt_s;
               dec_funct7_s = {ir_i[31:26], 1'b0};
            end else begin
               dec_imm_s    = sext32(imm_i_s);
               dec_funct7_s = 7'd0;
            end
            dec_ctrl_s[C_IMM] = 1'b1;
            dec_ctrl_s[C_RDW] = 1'b1;
         end
         OPC_OP: begin
            dec_ctrl_s[C_RDW] = 1'b1;
         end
         default: begin
            dec_imm_s              = '0;
            dec_ctrl_s             = 8'h00;
            dec_ctrl_s[C_ILLEGAL]  = 1'b1;
         end
      endcase
      if (ir_i[11:7] == 5'd0) begin
         dec_ctrl_s[C_RDW] = 1'b0;
      end else begin
         dec_ctrl_s[C_RDW] = dec_ctrl_s[C_RDW];
      end
   end

   logic [XLEN-1:0] pc_mem_r     [DEPTH];
   logic [6:0]      opcode_mem_r [DEPTH];
   logic [4:0]      rd_mem_r     [DEPTH];
   logic [4:0]      rs1_mem_r    [DEPTH];
   logic [4:0]      rs2_mem_r    [DEPTH];
   logic [2:0]      funct3_mem_r [DEPTH];
   logic [6:0]      funct7_mem_r [DEPTH];
   logic [XLEN-1:0] imm_mem_r    [DEPTH];
   logic [7:0]      ctrl_mem_r   [DEPTH];

   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          enq_s;
   logic          deq_s;
   logic          head_v_s;

   assign head_v_s = (count_r != '0);
   assign ready_o  = ~reset_i & (count_r != CW'(DEPTH));
   assign enq_s    = v_i & ready_o & ~flush_i;
   assign deq_s    = head_v_s & ready_i & ~flush_i;

   // Queue pointers and occupancy; flush empties the queue and drops the same-cycle input.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (enq_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (deq_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({enq_s, deq_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are only observed while counted as occupied.
   always_ff @(posedge clk_i) begin
      if (enq_s) begin
         pc_mem_r[wr_ptr_r]     <= pc_i;
         opcode_mem_r[wr_ptr_r] <= dec_opcode_s;
         rd_mem_r[wr_ptr_r]     <= dec_rd_s;
         rs1_mem_r[wr_ptr_r]    <= dec_rs1_s;
         rs2_mem_r[wr_ptr_r]    <= dec_rs2_s;
         funct3_mem_r[wr_ptr_r] <= dec_funct3_s;
         funct7_mem_r[wr_ptr_r] <= dec_funct7_s;
         imm_mem_r[wr_ptr_r]    <= dec_imm_s;
         ctrl_mem_r[wr_ptr_r]   <= dec_ctrl_s;
      end
   end

   // Head presentation; empty queue (including during reset) drives zeros.
   always_comb begin
      v_o      = head_v_s;
      count_o  = count_r;
      pc_o     = '0;
      opcode_o = 7'd0;
      rd_o     = 5'd0;
      rs1_o    = 5'd0;
      rs2_o    = 5'd0;
      funct3_o = 3'd0;
      funct7_o = 7'd0;
      imm_o    = '0;
      ctrl_o   = 8'h00;
      if (head_v_s) begin
         pc_o     = pc_mem_r[rd_ptr_r];
         opcode_o = opcode_mem_r[rd_ptr_r];
         rd_o     = rd_mem_r[rd_ptr_r];
         rs1_o    = rs1_mem_r[rd_ptr_r];
         rs2_o    = rs2_mem_r[rd_ptr_r];
         funct3_o = funct3_mem_r[rd_ptr_r];
         funct7_o = funct7_mem_r[rd_ptr_r];
         imm_o    = imm_mem_r[rd_ptr_r];
         ctrl_o   = ctrl_mem_r[rd_ptr_r];
      end else begin
         pc_o = '0;
      end
   end

endmodule
